// File: rtl/pulse_stretcher_if.sv
// ---------------------------------------------------------------------------
// pulse_stretcher_if
//   Groups the event input and the status/pulse outputs of pulse_stretcher.
//   The master drives the event strobe and observes the outputs; the slave
//   (the stretcher itself) consumes the strobe and drives the outputs.
//   PEND_WIDTH must match the PEND_WIDTH of the connected pulse_stretcher.
// ---------------------------------------------------------------------------
interface pulse_stretcher_if #(
    parameter int PEND_WIDTH = 4
);
    logic                  in;       // event strobe, rising edge = one event
    logic                  out;      // stretched, human-visible pulse
    logic                  busy;     // a blink or its trailing gap is running
    logic [PEND_WIDTH-1:0] pending;  // events queued behind the current blink
    logic                  drop;     // one-cycle strobe: event lost to saturation

    modport master (
        output in,
        input  out,
        input  busy,
        input  pending,
        input  drop
    );

    modport slave (
        input  in,
        output out,
        output busy,
        output pending,
        output drop
    );
endinterface : pulse_stretcher_if

// File: rtl/pulse_stretcher.sv
// ---------------------------------------------------------------------------
// pulse_stretcher
//   Turns each rising edge on bus.in into one blink on bus.out: high for
//   2^HOLD_WIDTH cycles, then forced low for 2^GAP_WIDTH cycles. Edges that
//   arrive during a blink or its gap are queued in a saturating counter so
//   every event stays visible as its own blink; an edge arriving while the
//   queue is full is reported on bus.drop.
//
//   Optional build macro: PULSE_STRETCHER_PWM_EN
//     Defined   - a free-running 4-bit PWM counter gates bus.out during the
//                 on-phase with a duty of PWM_DUTY/16. Timing, busy, pending
//                 and drop are unaffected.
//     Undefined - no PWM counter; bus.out is high for the whole on-phase.
//
//   All outputs are registered. Reset is asynchronous, active-low.
// ---------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int HOLD_WIDTH = 8,   // on-phase lasts 2^HOLD_WIDTH cycles
    parameter int GAP_WIDTH  = 8,   // gap lasts 2^GAP_WIDTH cycles
    parameter int PEND_WIDTH = 4,   // queue saturates at 2^PEND_WIDTH-1
    parameter int PWM_DUTY   = 8    // on-phase duty out of 16 (PWM build only)
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_stretcher_if.slave   bus
);

    // Illegal configurations stop elaboration rather than building silently.
    if (HOLD_WIDTH < 1 || GAP_WIDTH < 1 || PEND_WIDTH < 1 ||
        PWM_DUTY < 0 || PWM_DUTY > 16) begin : g_bad_params
        $error("pulse_stretcher: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    // Registered state
    state_t                state_q;
    logic [HOLD_WIDTH-1:0] hold_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [PEND_WIDTH-1:0] pend_q;
    logic                  in_q;
    logic                  out_q;
    logic                  busy_q;
    logic                  drop_q;

    // Next-state values
    state_t                state_d;
    logic [HOLD_WIDTH-1:0] hold_d;
    logic [GAP_WIDTH-1:0]  gap_d;
    logic [PEND_WIDTH-1:0] pend_d;
    logic                  out_d;
    logic                  busy_d;
    logic                  drop_d;

    logic                  event_s;   // rising edge seen this cycle
    logic                  consume;   // a new blink starts straight out of GAP
    logic                  hold_last; // final on-phase cycle
    logic                  gap_last;  // final gap cycle

    assign event_s   = bus.in & ~in_q;
    assign hold_last = &hold_q;
    assign gap_last  = &gap_q;

`ifdef PULSE_STRETCHER_PWM_EN
    localparam logic [4:0] DUTY = 5'(PWM_DUTY);

    logic [3:0] pwm_q;
    logic [3:0] pwm_d;

    assign pwm_d = pwm_q + 4'd1;

    // Free-running PWM phase counter; runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    // Next state, counters and queue bookkeeping.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;
        consume = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (event_s) begin
                    state_d = ST_ON;
                    hold_d  = '0;
                end
            end

            ST_ON: begin
                hold_d = hold_q + 1'b1;
                if (hold_last) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end

            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_last) begin
                    if (pend_q != '0 || event_s) begin
                        state_d = ST_ON;
                        hold_d  = '0;
                        consume = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Queue update. An edge arriving exactly when a queued blink is taken
        // cancels the decrement (or is itself the blink when nothing was
        // queued), so pending never moves and nothing is dropped then.
        if (state_q != ST_IDLE) begin
            if (event_s) begin
                if (!consume) begin
                    if (pend_q == PEND_MAX) begin
                        drop_d = 1'b1;
                    end else begin
                        pend_d = pend_q + 1'b1;
                    end
                end
            end else if (consume) begin
                pend_d = pend_q - 1'b1;
            end
        end
    end

    // Registered outputs derived from the next state.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
`ifdef PULSE_STRETCHER_PWM_EN
        out_d  = (state_d == ST_ON) && ({1'b0, pwm_d} < DUTY);
`else
        out_d  = (state_d == ST_ON);
`endif
    end

    // State, counters, edge detector and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            gap_q   <= '0;
            pend_q  <= '0;
            in_q    <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            in_q    <= bus.in;
            out_q   <= out_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.pending = pend_q;
    assign bus.drop    = drop_q;

endmodule : pulse_stretcher

// File: tb/tb_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretcher
//   Scoreboard bench for pulse_stretcher with 4-cycle on-phase, 4-cycle gap
//   and a queue of depth 3. The stimulus side drives bus.in once per cycle
//   and pushes the expected outputs for that clock edge, computed from a
//   blink-schedule model (blink start times, queued count). The monitor
//   pops one expectation per clock edge and compares all outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pulse_stretcher;

    localparam int HOLD_WIDTH = 2;
    localparam int GAP_WIDTH  = 2;
    localparam int PEND_WIDTH = 2;
    localparam int PWM_DUTY   = 8;

    localparam int ON_LEN   = 1 << HOLD_WIDTH;
    localparam int BLINK    = ON_LEN + (1 << GAP_WIDTH);
    localparam int PEND_CAP = (1 << PEND_WIDTH) - 1;

    logic clk;
    logic rst_n;

    pulse_stretcher_if #(.PEND_WIDTH(PEND_WIDTH)) bus ();

    pulse_stretcher #(
        .HOLD_WIDTH (HOLD_WIDTH),
        .GAP_WIDTH  (GAP_WIDTH),
        .PEND_WIDTH (PEND_WIDTH),
        .PWM_DUTY   (PWM_DUTY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- checks
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ----------------------------------------------------------------- model
    typedef struct {
        bit out;
        bit busy;
        int pending;
        bit drop;
    } exp_t;

    exp_t sb[$];

    int m_t      = 0;  // clock edge number
    bit m_active = 0;  // a blink (on + gap) is scheduled over this edge
    int m_start  = 0;  // edge at which the current blink began
    int m_queue  = 0;  // events waiting for their own blink
    bit m_prev   = 0;  // level of in at the previous edge
    int m_pwm    = 0;  // PWM phase after the edge

    // Expected outputs right after the next clock edge, given the level of
    // in sampled there and whether reset is held.
    task automatic model_edge(input bit rst_v, input bit in_v);
        exp_t e;
        bit   ev;
        e = '{out: 1'b0, busy: 1'b0, pending: 0, drop: 1'b0};
        if (!rst_v) begin
            m_active = 0;
            m_queue  = 0;
            m_prev   = 0;
            m_pwm    = 0;
        end else begin
            ev     = in_v && !m_prev;
            m_prev = in_v;
            m_t++;
            m_pwm  = (m_pwm + 1) % 16;
            if (m_active && (m_t == m_start + BLINK)) begin
                // Previous blink's gap has just finished.
                if (m_queue > 0 || ev) begin
                    m_start = m_t;
                    if (!ev) m_queue--;
                end else begin
                    m_active = 0;
                end
            end else if (m_active) begin
                if (ev) begin
                    if (m_queue == PEND_CAP) e.drop = 1'b1;
                    else m_queue++;
                end
            end else if (ev) begin
                m_active = 1;
                m_start  = m_t;
            end
            e.busy    = m_active;
            e.pending = m_queue;
`ifdef PULSE_STRETCHER_PWM_EN
            e.out = m_active && (m_t - m_start < ON_LEN) && (m_pwm < PWM_DUTY);
`else
            e.out = m_active && (m_t - m_start < ON_LEN);
`endif
        end
        sb.push_back(e);
    endtask

    // --------------------------------------------------------------- monitor
    int rise_cnt = 0;
    int drop_cnt = 0;
    bit prev_out = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out",     32'(bus.out),     32'(e.out));
                check("busy",    32'(bus.busy),    32'(e.busy));
                check("pending", 32'(bus.pending), 32'(e.pending));
                check("drop",    32'(bus.drop),    32'(e.drop));
                if (bus.out && !prev_out) rise_cnt++;
                if (bus.drop) drop_cnt++;
                prev_out = bus.out;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic step(input bit in_v, input bit rst_v);
        @(negedge clk);
        rst_n  = rst_v;
        bus.in = in_v;
        model_edge(rst_v, in_v);
    endtask

    // Drive len cycles; in is high at the listed cycle indices only.
    task automatic run_pattern(input int len, input int hi[$]);
        for (int i = 0; i < len; i++) begin
            step(i inside {hi}, 1'b1);
        end
    endtask

    // Let the monitor finish the last edge, then clear the blink counters.
    task automatic settle_and_clear();
        @(posedge clk);
        #2;
        rise_cnt = 0;
        drop_cnt = 0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n  = 1'b0;
        bus.in = 1'b0;
        model_edge(1'b0, 1'b0);
        #1;
        check("rst_async_out",     32'(bus.out),     32'd0);
        check("rst_async_busy",    32'(bus.busy),    32'd0);
        check("rst_async_pending", 32'(bus.pending), 32'd0);
        check("rst_async_drop",    32'(bus.drop),    32'd0);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int density;
        rst_n  = 1'b0;
        bus.in = 1'b0;
        #1;
        check("reset_out",     32'(bus.out),     32'd0);
        check("reset_busy",    32'(bus.busy),    32'd0);
        check("reset_pending", 32'(bus.pending), 32'd0);
        check("reset_drop",    32'(bus.drop),    32'd0);

        // Single 1-cycle strobe: one 4-high / 4-low blink.
        run_pattern(30, '{10});
        settle();
`ifndef PULSE_STRETCHER_PWM_EN
        check("t1_blinks", 32'(rise_cnt), 32'd1);
`endif
        settle_and_clear();

        // in held high for 20 cycles: still one event.
        run_pattern(40, '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19,
                          20, 21, 22, 23, 24, 25, 26, 27, 28, 29});
        settle();
`ifndef PULSE_STRETCHER_PWM_EN
        check("t2_blinks", 32'(rise_cnt), 32'd1);
`endif
        check("t2_drops", 32'(drop_cnt), 32'd0);
        settle_and_clear();

        // Three strobes queued behind the first: four back-to-back blinks.
        run_pattern(50, '{10, 12, 14, 16});
        settle();
`ifndef PULSE_STRETCHER_PWM_EN
        check("t3_blinks", 32'(rise_cnt), 32'd4);
`endif
        check("t3_drops", 32'(drop_cnt), 32'd0);
        settle_and_clear();

        // Queue saturates: two strobes dropped, five blinks in all.
        run_pattern(70, '{10, 12, 14, 16, 19, 21, 23});
        settle();
`ifndef PULSE_STRETCHER_PWM_EN
        check("t4_blinks", 32'(rise_cnt), 32'd5);
`endif
        check("t4_drops", 32'(drop_cnt), 32'd2);
        settle_and_clear();

        // Strobe on the final gap cycle with one event queued.
        run_pattern(50, '{10, 12, 18});
        settle();
`ifndef PULSE_STRETCHER_PWM_EN
        check("t5_blinks", 32'(rise_cnt), 32'd3);
`endif
        check("t5_drops", 32'(drop_cnt), 32'd0);
        settle_and_clear();

        // Async reset mid-on-phase with two events queued.
        run_pattern(20, '{10, 12, 14, 16});
        reset_pulse();
        settle_and_clear();
        run_pattern(40, '{});
        settle();
        check("t6_no_blink_after_reset", 32'(rise_cnt), 32'd0);
        settle_and_clear();

        // Randomised traffic at varying densities with occasional resets.
        density = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) density = $urandom_range(2, 95);
            if ($urandom_range(0, 599) == 0) begin
                step(1'b0, 1'b0);
            end else begin
                step($urandom_range(0, 99) < density, 1'b1);
            end
        end
        run_pattern(60, '{});
        settle();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pulse_stretcher
